// File: rtl/instruction_cache_controller_sa_pkg.sv
// Shared FSM encoding and address-split helpers for the set-associative instruction cache.
package instruction_cache_controller_sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2,
        ST_FLUSH  = 2'd3
    } icache_state_e;

    function automatic int f_off_w(input int line_words, input int instr_w);
        return $clog2(line_words * instr_w / 8);
    endfunction

    function automatic int f_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int f_tag_w(input int addr_w, input int sets, input int line_words,
                                   input int instr_w);
        return addr_w - f_idx_w(sets) - f_off_w(line_words, instr_w);
    endfunction

endpackage

// File: rtl/instruction_cache_controller_sa_way_array.sv
// One cache way: {tag,line} storage, synchronous read, single write port, one-cycle read latency.
// No reset on the array so it maps onto block RAM; validity is tracked outside.
module icache_way_array
    import instruction_cache_controller_sa_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 152
) (
    input  logic                     clk_i,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_dat,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_dat
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_dat;

    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/instruction_cache_controller_sa.sv
// Set-associative instruction cache (1 or 2 ways, per-set LRU) with whole-line refill and flush.
// Hit: data one cycle after lookup (2-cycle issue rate); miss holds mem_req_o until mem_valid_i.
module instruction_cache_controller_sa
    import instruction_cache_controller_sa_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 256,
    parameter int WAYS       = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          fetch_req_i,
    input  logic [ADDR_W-1:0]             fetch_addr_i,
    output logic                          fetch_ready_o,
    output logic                          fetch_valid_o,
    output logic [INSTR_W-1:0]            fetch_instr_o,
    output logic                          mem_req_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    input  logic                          mem_valid_i,
    input  logic [LINE_WORDS*INSTR_W-1:0] mem_line_i,
    input  logic                          flush_i,
    output logic                          flush_done_o
);

    localparam int LINE_W  = LINE_WORDS * INSTR_W;
    localparam int OFF_W   = f_off_w(LINE_WORDS, INSTR_W);
    localparam int IDX_W   = f_idx_w(SETS);
    localparam int TAG_W   = f_tag_w(ADDR_W, SETS, LINE_WORDS, INSTR_W);
    localparam int BOFF_W  = $clog2(INSTR_W / 8);
    localparam int WSEL_W  = OFF_W - BOFF_W;
    localparam int ENTRY_W = TAG_W + LINE_W;
    localparam int MAXW    = 2;

    icache_state_e r_state;
    icache_state_e w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [SETS-1:0]    r_valid [MAXW];
    logic [SETS-1:0]    r_lru;
    logic               r_flush_pend;
    logic [IDX_W-1:0]   r_flush_cnt;
    logic               r_fetch_valid;
    logic [INSTR_W-1:0] r_fetch_instr;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_flush_done;

    logic [IDX_W-1:0]   w_req_idx;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [WSEL_W-1:0]  w_wsel;
    logic [ENTRY_W-1:0] w_rd_dat [MAXW];
    logic [MAXW-1:0]    w_hit_vec;
    logic               w_hit;
    logic               w_hit_way;
    logic [LINE_W-1:0]  w_hit_line;
    logic [INSTR_W-1:0] w_hit_word;
    logic [INSTR_W-1:0] w_fill_word;
    logic               w_victim;
    logic               w_accept;
    logic               w_ram_we;
    logic               w_flush_last;
    logic               w_unused;

    assign w_req_idx    = fetch_addr_i[OFF_W +: IDX_W];
    assign w_idx        = r_addr[OFF_W +: IDX_W];
    assign w_tag        = r_addr[ADDR_W-1 -: TAG_W];
    assign w_wsel       = r_addr[BOFF_W +: WSEL_W];
    assign w_unused     = ^{fetch_addr_i[BOFF_W-1:0], r_addr[BOFF_W-1:0]};
    assign w_flush_last = (r_flush_cnt == IDX_W'(SETS - 1));

    // A pending flush or one arriving this cycle wins over a fetch, so stop advertising ready.
    assign fetch_ready_o = (r_state == ST_IDLE) && !r_flush_pend && !flush_i && !rst_i;
    assign w_accept      = fetch_req_i && fetch_ready_o;
    assign w_ram_we      = (r_state == ST_REFILL) && mem_valid_i;

    for (genvar w = 0; w < MAXW; w++) begin : g_ways
        if (w < WAYS) begin : g_ram
            icache_way_array #(
                .DEPTH  (SETS),
                .DATA_W (ENTRY_W)
            ) u_way (
                .clk_i     (clk_i),
                .i_rd_en   (w_accept),
                .i_rd_addr (w_req_idx),
                .o_rd_dat  (w_rd_dat[w]),
                .i_wr_en   (w_ram_we && (w_victim == 1'(w))),
                .i_wr_addr (w_idx),
                .i_wr_dat  ({w_tag, mem_line_i})
            );
        end else begin : g_tie
            assign w_rd_dat[w] = '0;
        end
    end

    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < MAXW; w++) begin
            if (w < WAYS) begin
                w_hit_vec[w] = r_valid[w][w_idx] && (w_rd_dat[w][ENTRY_W-1 -: TAG_W] == w_tag);
            end
        end
    end

    assign w_hit       = |w_hit_vec;
    assign w_hit_way   = w_hit_vec[1];
    assign w_hit_line  = w_hit_way ? w_rd_dat[1][LINE_W-1:0] : w_rd_dat[0][LINE_W-1:0];
    assign w_hit_word  = w_hit_line[w_wsel*INSTR_W +: INSTR_W];
    assign w_fill_word = mem_line_i[w_wsel*INSTR_W +: INSTR_W];

    // Fill the lowest invalid way first; only fall back to LRU when the set is full.
    always_comb begin
        w_victim = 1'b0;
        if (WAYS > 1 && r_valid[0][w_idx]) begin
            w_victim = r_valid[1][w_idx] ? r_lru[w_idx] : 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (flush_i || r_flush_pend) begin
                    w_state_nxt = ST_FLUSH;
                end else if (fetch_req_i) begin
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: w_state_nxt = w_hit ? ST_IDLE : ST_REFILL;
            ST_REFILL: begin
                if (mem_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (w_flush_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr        <= '0;
            r_flush_pend  <= 1'b0;
            r_flush_cnt   <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_flush_done  <= 1'b0;
        end else begin
            r_fetch_valid <= 1'b0;
            r_flush_done  <= 1'b0;
            if (w_accept) begin
                r_addr <= fetch_addr_i;
            end
            case (r_state)
                ST_IDLE: begin
                    if (flush_i || r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                        r_flush_cnt  <= '0;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_fetch_valid <= 1'b1;
                        r_fetch_instr <= w_hit_word;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                ST_REFILL: begin
                    if (mem_valid_i) begin
                        r_fetch_valid <= 1'b1;
                        r_fetch_instr <= w_fill_word;
                        r_mem_req     <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (w_flush_last) begin
                        r_flush_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Flushes during an access are remembered; during a flush they merge into it.
            if (flush_i && (r_state == ST_LOOKUP || r_state == ST_REFILL)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < MAXW; w++) begin
                r_valid[w] <= '0;
            end
            r_lru <= '0;
        end else begin
            if (r_state == ST_FLUSH) begin
                for (int w = 0; w < MAXW; w++) begin
                    r_valid[w][r_flush_cnt] <= 1'b0;
                end
                r_lru[r_flush_cnt] <= 1'b0;
            end else if (r_state == ST_LOOKUP && w_hit) begin
                r_lru[w_idx] <= ~w_hit_way;
            end else if (w_ram_we) begin
                r_valid[w_victim][w_idx] <= 1'b1;
                r_lru[w_idx]             <= ~w_victim;
            end
        end
    end

    assign fetch_valid_o = r_fetch_valid;
    assign fetch_instr_o = r_fetch_instr;
    assign mem_req_o     = r_mem_req;
    assign mem_addr_o    = r_mem_addr;
    assign flush_done_o  = r_flush_done;

endmodule
